// File: rtl/adder_share_arb_pkg.sv
// Shared types and default sizing for the round-robin shared-adder arbiter.
package adder_arb_pkg;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);

    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;
    typedef logic [DEF_DATA_WIDTH:0]   sum_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        sum_t                sum;
    } rsp_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/adder_share_arb_if.sv
// Request (per-channel operand pairs) and response (sum + id) handshake bundle.
interface adder_share_arb_if #(
    parameter int DATA_WIDTH = adder_arb_pkg::DEF_DATA_WIDTH,
    parameter int NUM_REQ    = adder_arb_pkg::DEF_NUM_REQ
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic [DATA_WIDTH:0]                rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/adder_share_arb_carry_select_adder.sv
// Combinational carry-select adder: low half ripples, upper half is precomputed
// for both carry-in values and selected by the low-half carry.
module carry_select_adder #(
    parameter int DATA_WIDTH = 24
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH:0]   result
);
    localparam int LO_W = DATA_WIDTH / 2;
    localparam int HI_W = DATA_WIDTH - LO_W;

    logic [LO_W:0] lo_sum;
    logic [HI_W:0] hi_sum0;
    logic [HI_W:0] hi_sum1;

    assign lo_sum  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
    assign hi_sum0 = {1'b0, a[DATA_WIDTH-1:LO_W]} + {1'b0, b[DATA_WIDTH-1:LO_W]};
    assign hi_sum1 = {1'b0, a[DATA_WIDTH-1:LO_W]} + {1'b0, b[DATA_WIDTH-1:LO_W]}
                     + (HI_W+1)'(1);

    assign result = {(lo_sum[LO_W] ? hi_sum1 : hi_sum0), lo_sum[LO_W-1:0]};

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter granting one requester per cycle onto a shared adder,
// with a single registered result slot on a valid/ready response port.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic              clk,
    input  logic              rst,
    adder_share_arb_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [DATA_WIDTH:0] sum;
    } rsp_reg_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    rsp_reg_t            rsp_q, rsp_d;

    logic [ID_W:0]       pick;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic                can_accept;
    logic                xfer;
    logic [NUM_REQ-1:0]  req_ready;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [DATA_WIDTH:0]   sum;

    // Returns {found, index}: first set bit scanning upward from ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] id;
        int unsigned     idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            id  = ID_W'(idx);
            if (!res[ID_W] && valid[id]) begin
                res = {1'b1, id};
            end
        end
        return res;
    endfunction

    assign pick      = rr_pick(bus.req_valid, ptr_q);
    assign grant_vld = pick[ID_W];
    assign grant_idx = pick[ID_W-1:0];

    // Reset blocks both handshakes so nothing is accepted or delivered while it is held.
    assign can_accept = !rst && ((state_q == EMPTY) || bus.rsp_ready);
    assign xfer       = grant_vld && can_accept;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign op_a = bus.req_a[grant_idx];
    assign op_b = bus.req_b[grant_idx];

    carry_select_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a      (op_a),
        .b      (op_b),
        .result (sum)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rsp_d   = rsp_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (bus.rsp_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            rsp_d.id  = grant_idx;
            rsp_d.sum = sum;
            ptr_d     = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == FULL) && !rst;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.rsp_sum   = rsp_q.sum;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed + random bench; a driver model predicts grants and queues expected
// results, a separate monitor pops and compares on each response handshake.
module tb_adder_share_arb;
    import adder_arb_pkg::*;

    localparam int N = DEF_NUM_REQ;
    localparam int W = DEF_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_share_arb_if #(.DATA_WIDTH(W), .NUM_REQ(N)) bus ();

    adder_share_arb #(
        .DATA_WIDTH (W),
        .NUM_REQ    (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    rsp_t     sb[$];
    int       ptr_m  = 0;
    bit       full_m = 1'b0;
    operand_t a_v[N];
    operand_t b_v[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check and advance the reference model at +1.
    // exp_g >= 0: hand-expected grant; -1: no grant expected; -2: model only.
    task automatic step(input logic [N-1:0] vld, input logic rr, input logic r,
                        input int exp_g, output int acc);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] oh;
        int           g;
        bit           can;
        rsp_t         e;
        @(negedge clk);
        rst           = r;
        bus.req_valid = vld;
        bus.rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = a_v[i];
            bus.req_b[i] = b_v[i];
        end
        #1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(full_m && !r));
        g = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr_m + i) % N;
            if (g < 0 && vld[k]) g = k;
        end
        can     = !r && (!full_m || rr);
        exp_rdy = '0;
        acc     = -1;
        if (can && g >= 0) begin
            exp_rdy[g] = 1'b1;
            acc        = g;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (exp_g >= 0) begin
            oh        = '0;
            oh[exp_g] = 1'b1;
            chk("grant", 64'(bus.req_ready), 64'(oh));
        end else if (exp_g == -1) begin
            chk("no_grant", 64'(bus.req_ready), 64'(0));
        end
        if (r) begin
            full_m = 1'b0;
            ptr_m  = 0;
            sb.delete();
        end else if (acc >= 0) begin
            e.id  = DEF_ID_W'(acc);
            e.sum = sum_t'(a_v[acc]) + sum_t'(b_v[acc]);
            sb.push_back(e);
            ptr_m  = (acc + 1) % N;
            full_m = 1'b1;
        end else if (full_m && rr) begin
            full_m = 1'b0;
        end
    endtask

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected act=id%0h/sum%0h exp=none", bus.rsp_id, bus.rsp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rsp_sum", 64'(bus.rsp_sum), 64'(e.sum));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int            acc;
        logic [N-1:0]  pend;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset then idle
        step('0, 1'b1, 1'b1, -1, acc);
        step('0, 1'b1, 1'b1, -1, acc);
        repeat (10) step('0, 1'b1, 1'b0, -1, acc);
        chk("rst_id", 64'(bus.rsp_id), 64'(0));
        chk("rst_sum", 64'(bus.rsp_sum), 64'(0));

        // All requesters valid, back-to-back grants 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            a_v[i] = operand_t'(i + 1);
            b_v[i] = 24'h000100;
        end
        step(4'b1111, 1'b1, 1'b0, 0, acc);
        step(4'b1111, 1'b1, 1'b0, 1, acc);
        step(4'b1111, 1'b1, 1'b0, 2, acc);
        step(4'b1111, 1'b1, 1'b0, 3, acc);
        step(4'b1111, 1'b1, 1'b0, 0, acc);
        step('0, 1'b1, 1'b0, -1, acc);

        // Backpressure: hold for 5 cycles, then drain and refill together
        step(4'b1111, 1'b1, 1'b0, 1, acc);
        repeat (5) begin
            step(4'b1111, 1'b0, 1'b0, -1, acc);
            chk("bp_id", 64'(bus.rsp_id), 64'(1));
            chk("bp_sum", 64'(bus.rsp_sum), 64'h102);
        end
        step(4'b1111, 1'b1, 1'b0, 2, acc);
        step('0, 1'b1, 1'b0, -1, acc);

        // Overflow into the carry-out bit
        a_v[2] = 24'hFFFFFF;
        b_v[2] = 24'hFFFFFF;
        step(4'b0100, 1'b1, 1'b0, 2, acc);
        step('0, 1'b0, 1'b0, -1, acc);
        chk("ovf_sum", 64'(bus.rsp_sum), 64'h1FFFFFE);
        chk("ovf_id", 64'(bus.rsp_id), 64'(2));
        a_v[1] = 24'hFFFFFF;
        b_v[1] = 24'h000001;
        step(4'b0010, 1'b1, 1'b0, 1, acc);
        step('0, 1'b0, 1'b0, -1, acc);
        chk("carry_sum", 64'(bus.rsp_sum), 64'h1000000);
        chk("carry_id", 64'(bus.rsp_id), 64'(1));
        step('0, 1'b1, 1'b0, -1, acc);

        // Fairness/skip from ptr=2, then late requester 0 with ptr=1
        step(4'b1010, 1'b1, 1'b0, 3, acc);
        step(4'b1010, 1'b1, 1'b0, 1, acc);
        step(4'b1010, 1'b1, 1'b0, 3, acc);
        step(4'b0001, 1'b1, 1'b0, 0, acc);
        step(4'b1011, 1'b1, 1'b0, 1, acc);
        step(4'b1011, 1'b1, 1'b0, 3, acc);
        step(4'b1011, 1'b1, 1'b0, 0, acc);
        step('0, 1'b1, 1'b0, -1, acc);

        // Reset while FULL and stalled: result discarded, pointer back to 0
        step(4'b0100, 1'b1, 1'b0, 2, acc);
        step('0, 1'b0, 1'b0, -1, acc);
        step('0, 1'b0, 1'b1, -1, acc);
        step('0, 1'b1, 1'b0, -1, acc);
        step(4'b1111, 1'b1, 1'b0, 0, acc);
        step('0, 1'b1, 1'b0, -1, acc);

        // Random traffic, requesters hold until accepted
        pend = '0;
        repeat (1000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    a_v[i]  = ($urandom_range(0, 7) == 0) ? '1 : operand_t'($urandom());
                    b_v[i]  = ($urandom_range(0, 7) == 0) ? '1 : operand_t'($urandom());
                end
            end
            step(pend, $urandom_range(0, 3) != 0, 1'b0, -2, acc);
            if (acc >= 0) pend[acc] = 1'b0;
        end
        repeat (3) step('0, 1'b1, 1'b0, -1, acc);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
